// File: rtl/aes_ced_round_ctrl_if.sv
// Bundle between the CED round controller (master) and its cipher wrapper / round datapath (slave).
interface aes_ced_round_ctrl_if #(
    parameter int NR     = 10,
    parameter int RIDX_W = 4,
    parameter int FCNT_W = 8
);
    // start is a one-cycle request taken only while busy=0; every taken start
    // yields exactly one done pulse, on the same edge that drops busy.
    logic              start;
    logic [1:0]        ced_mode;
    logic [NR:0]       ced_round_mask;
    logic [127:0]      round_in;
    logic [127:0]      state_out;
    logic [127:0]      state_alpha_out;
    logic              ced_pass;
    logic [RIDX_W-1:0] round_idx;
    logic              busy;
    logic              done;
    logic              fault_detected;
    logic [RIDX_W-1:0] fault_round;
    logic [FCNT_W-1:0] fault_count;
    logic [1:0]        dbg_state;

    modport master (
        input  start, ced_mode, ced_round_mask, round_in,
        output state_out, state_alpha_out, ced_pass, round_idx, busy, done,
               fault_detected, fault_round, fault_count, dbg_state
    );

    modport slave (
        output start, ced_mode, ced_round_mask, round_in,
        input  state_out, state_alpha_out, ced_pass, round_idx, busy, done,
               fault_detected, fault_round, fault_count, dbg_state
    );
endinterface

// File: rtl/aes_ced_round_ctrl.sv
// AES round sequencer with alpha-permuted recomputation: each checked round is
// evaluated twice (plain, then column-rotated) and the two results are compared.
module aes_ced_round_ctrl #(
    parameter int NR     = 10,
    parameter int RIDX_W = 4,
    parameter int FCNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_ced_round_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMP   = 2'd1,
        RECOMP = 2'd2
    } state_e;

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NR);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [NR:0]       mask_q, mask_d;
    logic [127:0]      st_q, st_d;
    logic [127:0]      save_q, save_d;
    logic [RIDX_W-1:0] ridx_q, ridx_d;
    logic [RIDX_W-1:0] fround_q, fround_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fdet_q, fdet_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              pass_q, pass_d;
    logic              chk;
    logic              last;
    logic              mismatch;

    // Byte k is bits [8k+7:8k]; a 4-byte rotate moves whole columns.
    function automatic logic [127:0] alpha(input logic [127:0] x);
        return {x[31:0], x[127:32]};
    endfunction

    function automatic logic [127:0] inv_alpha(input logic [127:0] x);
        return {x[95:0], x[127:96]};
    endfunction

    always_comb begin
        unique case (mode_q)
            2'b00:   chk = 1'b0;
            2'b10:   chk = mask_q[ridx_q];
            default: chk = 1'b1;
        endcase
    end

    assign last     = (ridx_q == LAST_ROUND);
    assign mismatch = (inv_alpha(bus.round_in) != save_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        st_d     = st_q;
        save_d   = save_q;
        ridx_d   = ridx_q;
        fdet_d   = fdet_q;
        fround_d = fround_q;
        fcnt_d   = fcnt_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = COMP;
                    ridx_d   = '0;
                    mode_d   = bus.ced_mode;
                    mask_d   = bus.ced_round_mask;
                    fdet_d   = 1'b0;
                    fround_d = '0;
                end
            end
            COMP: begin
                if (chk) begin
                    save_d  = bus.round_in;
                    state_d = RECOMP;
                end else begin
                    st_d = bus.round_in;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ridx_d = ridx_q + RIDX_W'(1);
                    end
                end
            end
            RECOMP: begin
                if (mismatch) begin
                    fdet_d = 1'b1;
                    if (!fdet_q) fround_d = ridx_q;
                    if (fcnt_q != '1) fcnt_d = fcnt_q + FCNT_W'(1);
                end
                // Abort mode wipes the state so no faulty ciphertext leaks out.
                if (mismatch && (mode_q == 2'b11)) begin
                    st_d    = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    st_d = save_q;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ridx_d  = ridx_q + RIDX_W'(1);
                        state_d = COMP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        pass_d = (state_d == RECOMP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            mask_q   <= '0;
            st_q     <= '0;
            save_q   <= '0;
            ridx_q   <= '0;
            fround_q <= '0;
            fcnt_q   <= '0;
            fdet_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            st_q     <= st_d;
            save_q   <= save_d;
            ridx_q   <= ridx_d;
            fround_q <= fround_d;
            fcnt_q   <= fcnt_d;
            fdet_q   <= fdet_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.state_out       = st_q;
    assign bus.state_alpha_out = alpha(st_q);
    assign bus.ced_pass        = pass_q;
    assign bus.round_idx       = ridx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.fault_detected  = fdet_q;
    assign bus.fault_round     = fround_q;
    assign bus.fault_count     = fcnt_q;
    assign bus.dbg_state       = state_q;
endmodule
